// File: rtl/icevga_fifo_reader.sv
// Drains an IDT7201-style async FIFO (-RD strobe, -EF watch) into a 2-entry valid/ready buffer.
// Optional ICEVGA_FIFO_STATS_EN adds a wrapping 16-bit rd_count of captured bytes.
module icevga_fifo_reader #(
    parameter int RD_LOW_CYCLES  = 8,
    parameter int RD_HIGH_CYCLES = 4
) (
    input  logic        clk,
    input  logic        disp_rst,
    output logic        fifo_rd,
    input  logic        fifo_ef,
    input  logic [7:0]  fifo_d,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
`ifdef ICEVGA_FIFO_STATS_EN
    ,
    output logic [15:0] rd_count
`endif
);

    localparam int TMR_MAX = (RD_LOW_CYCLES > RD_HIGH_CYCLES) ? RD_LOW_CYCLES : RD_HIGH_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_LOW,
        RD_HIGH
    } state_t;

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic             ef_meta;
    logic             ef_s;
    logic [1:0]       count;
    logic [7:0]       slot1;
    logic             capture;
    logic             pop;

    assign capture = (state == RD_LOW) && (timer == '0);
    assign pop     = out_valid && out_ready;

    // -EF is asynchronous to clk; reset forces it to read as empty
    always_ff @(posedge clk) begin
        if (!disp_rst) begin
            ef_meta <= 1'b0;
            ef_s    <= 1'b0;
        end else begin
            ef_meta <= fifo_ef;
            ef_s    <= ef_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!disp_rst) begin
            state   <= IDLE;
            timer   <= '0;
            fifo_rd <= 1'b1;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ef_s && (count < 2'd2)) begin
                        state   <= RD_LOW;
                        timer   <= TMR_W'(RD_LOW_CYCLES - 1);
                        fifo_rd <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                RD_LOW: begin
                    if (timer == '0) begin
                        state   <= RD_HIGH;
                        timer   <= TMR_W'(RD_HIGH_CYCLES - 1);
                        fifo_rd <= 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                RD_HIGH: begin
                    if (timer == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    fifo_rd <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // out_data is the head slot and slot1 the tail, so the head is always presented registered
    always_ff @(posedge clk) begin
        if (!disp_rst) begin
            count     <= 2'd0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            slot1     <= 8'h00;
        end else begin
            case ({capture, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        out_data  <= fifo_d;
                        out_valid <= 1'b1;
                        count     <= 2'd1;
                    end else begin
                        slot1 <= fifo_d;
                        count <= 2'd2;
                    end
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        out_data <= slot1;
                        count    <= 2'd1;
                    end else begin
                        out_valid <= 1'b0;
                        count     <= 2'd0;
                    end
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        out_data <= slot1;
                        slot1    <= fifo_d;
                    end else begin
                        out_data <= fifo_d;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ICEVGA_FIFO_STATS_EN
    always_ff @(posedge clk) begin
        if (!disp_rst) begin
            rd_count <= 16'h0000;
        end else if (capture) begin
            rd_count <= rd_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icevga_fifo_reader.sv
// Self-checking bench for icevga_fifo_reader: a queue-based external FIFO model plus a sink scoreboard.
// With ICEVGA_FIFO_STATS_EN defined it also exercises rd_count.
module tb_icevga_fifo_reader;

    localparam int RD_LOW  = 8;
    localparam int RD_HIGH = 4;
    localparam int PERIOD  = RD_LOW + RD_HIGH + 1;

    logic        clk = 1'b0;
    logic        disp_rst;
    logic        fifo_rd;
    logic        fifo_ef = 1'b0;
    logic [7:0]  fifo_d = 8'h00;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
`ifdef ICEVGA_FIFO_STATS_EN
    logic [15:0] rd_count;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic       src_en = 1'b0;
    logic [7:0] src_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         got_cyc[$];
    int         fall_cyc[$];
    int         low_len[$];
    int         valid_cycles = 0;
    int         run = 0;
    logic       model_prev_rd = 1'b1;
    logic       mon_prev_rd = 1'b1;

    icevga_fifo_reader #(
        .RD_LOW_CYCLES (RD_LOW),
        .RD_HIGH_CYCLES(RD_HIGH)
    ) dut (
        .clk      (clk),
        .disp_rst (disp_rst),
        .fifo_rd  (fifo_rd),
        .fifo_ef  (fifo_ef),
        .fifo_d   (fifo_d),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy)
`ifdef ICEVGA_FIFO_STATS_EN
        ,
        .rd_count (rd_count)
`endif
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        if (RD_HIGH < 3) $error("[TB] RD_HIGH_CYCLES=%0d is illegal, minimum is 3", RD_HIGH);
    end

    // External FIFO: a -RD rising edge consumes the head byte; -EF is low when empty or disabled
    initial forever begin
        @(negedge clk);
        if (model_prev_rd === 1'b0 && fifo_rd === 1'b1 && src_q.size() > 0)
            exp_q.push_back(src_q.pop_front());
        model_prev_rd = fifo_rd;
        fifo_d  = (src_q.size() > 0) ? src_q[0] : 8'($urandom);
        fifo_ef = src_en && (src_q.size() > 0);
    end

    initial forever begin
        @(negedge clk);
        if (mon_prev_rd === 1'b1 && fifo_rd === 1'b0) fall_cyc.push_back(cyc);
        if (fifo_rd === 1'b0) run++;
        else if (run > 0) begin
            low_len.push_back(run);
            run = 0;
        end
        mon_prev_rd = fifo_rd;
        if (out_valid === 1'b1) valid_cycles++;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            got_q.push_back(out_data);
            got_cyc.push_back(cyc);
        end
    end

    function automatic logic [7:0] got_at(input int i);
        if (i < got_q.size()) return got_q[i];
        return 8'hxx;
    endfunction

    task automatic clear_logs();
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
        fall_cyc.delete();
        low_len.delete();
        valid_cycles = 0;
    endtask

    task automatic wait_got(input int n, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (got_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic quiesce();
        bit ok;
        src_en = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy === 1'b0 && out_valid === 1'b0 && fifo_rd === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL quiesce: busy=%b out_valid=%b fifo_rd=%b, required 0/0/1", busy, out_valid, fifo_rd);
        end
        repeat (3) @(posedge clk);
        #1;
        src_q.delete();
        clear_logs();
    endtask

    task automatic test_reset();
        int k;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (fifo_rd !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_hold: fifo_rd=%b out_valid=%b, required 1/0", fifo_rd, out_valid);
            end
        end
        checks++;
        if (out_data !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_values: out_data=%h busy=%b, required 00/0", out_data, busy);
        end
        @(posedge clk);
        #1 disp_rst = 1'b1;
        k = -1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (fifo_rd === 1'b0) begin
                k = i;
                break;
            end
        end
        checks++;
        if (k != 3) begin
            errors++;
            $display("[TB] FAIL first_read_delay: got %0d edges, required 3", k);
        end
    endtask

    task automatic test_single_byte();
        bit ok;
        int len;
        src_q.push_back(8'hA5);
        src_q.push_back(8'hEE);
        out_ready = 1'b1;
        @(posedge clk);
        #1 src_en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fall_cyc.size() > 0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL single_start: falls=%0d, required 1 within 20 cycles", fall_cyc.size());
        end
        repeat (2) @(posedge clk);
        #1 src_en = 1'b0;
        repeat (40) @(negedge clk);
        len = (low_len.size() > 0) ? low_len[0] : -1;
        checks++;
        if (fall_cyc.size() != 1 || low_len.size() != 1 || len != RD_LOW) begin
            errors++;
            $display("[TB] FAIL single_pulse: pulses=%0d low_len=%0d, required 1 pulse of %0d", fall_cyc.size(), len, RD_LOW);
        end
        checks++;
        if (got_q.size() != 1 || got_at(0) !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL single_data: count=%0d byte=%h, required 1 byte a5", got_q.size(), got_at(0));
        end
        checks++;
        if (valid_cycles != 1) begin
            errors++;
            $display("[TB] FAIL single_valid_len: %0d cycles, required 1", valid_cycles);
        end
    endtask

    task automatic test_stream();
        bit ok;
        for (int i = 0; i < 16; i++) src_q.push_back(8'(i));
        out_ready = 1'b1;
        @(posedge clk);
        #1 src_en = 1'b1;
        wait_got(16, 16 * PERIOD + 50, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL stream_timeout: got %0d bytes, required 16", got_q.size());
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got_at(i) !== 8'(i)) begin
                errors++;
                $display("[TB] FAIL stream_byte[%0d]: got %h, required %h", i, got_at(i), 8'(i));
            end
        end
        checks++;
        if (fall_cyc.size() != 16) begin
            errors++;
            $display("[TB] FAIL stream_reads: got %0d, required 16", fall_cyc.size());
        end
        for (int i = 1; i < fall_cyc.size(); i++) begin
            checks++;
            if (fall_cyc[i] - fall_cyc[i-1] != PERIOD) begin
                errors++;
                $display("[TB] FAIL stream_period[%0d]: got %0d, required %0d", i, fall_cyc[i] - fall_cyc[i-1], PERIOD);
            end
        end
        for (int i = 0; i < low_len.size(); i++) begin
            checks++;
            if (low_len[i] != RD_LOW) begin
                errors++;
                $display("[TB] FAIL stream_low_len[%0d]: got %0d, required %0d", i, low_len[i], RD_LOW);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [7:0] b[4];
        for (int i = 0; i < 4; i++) begin
            b[i] = 8'($urandom);
            src_q.push_back(b[i]);
        end
        out_ready = 1'b0;
        @(posedge clk);
        #1 src_en = 1'b1;
        repeat (60) @(negedge clk);
        checks++;
        if (fall_cyc.size() != 2 || fifo_rd !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_stall: reads=%0d fifo_rd=%b, required 2 reads and fifo_rd=1", fall_cyc.size(), fifo_rd);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== b[0]) begin
            errors++;
            $display("[TB] FAIL bp_head: out_valid=%b out_data=%h, required 1/%h", out_valid, out_data, b[0]);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_got(4, 100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL bp_resume: got %0d bytes, required 4", got_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_at(i) !== b[i]) begin
                errors++;
                $display("[TB] FAIL bp_byte[%0d]: got %h, required %h", i, got_at(i), b[i]);
            end
        end
        checks++;
        if (got_cyc.size() < 2 || got_cyc[1] - got_cyc[0] != 1) begin
            errors++;
            $display("[TB] FAIL bp_consecutive: gap=%0d, required 1", (got_cyc.size() < 2) ? -1 : got_cyc[1] - got_cyc[0]);
        end
    endtask

    task automatic test_random_ready();
        bit ok;
        logic [7:0] sent[$];
        for (int i = 0; i < 24; i++) begin
            sent.push_back(8'($urandom));
            src_q.push_back(sent[i]);
        end
        @(posedge clk);
        #1 src_en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 24 * PERIOD * 4; i++) begin
            @(posedge clk);
            #1 out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (got_q.size() >= 24) begin
                ok = 1'b1;
                break;
            end
        end
        out_ready = 1'b1;
        checks++;
        if (!ok || got_q.size() != 24) begin
            errors++;
            $display("[TB] FAIL rand_count: got %0d bytes, required 24", got_q.size());
        end
        for (int i = 0; i < 24; i++) begin
            checks++;
            if (got_at(i) !== sent[i]) begin
                errors++;
                $display("[TB] FAIL rand_byte[%0d]: got %h, required %h", i, got_at(i), sent[i]);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        bit ok;
        src_q.push_back(8'($urandom));
        src_q.push_back(8'($urandom));
        out_ready = 1'b1;
        @(posedge clk);
        #1 src_en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fifo_rd === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL midrst_start: fifo_rd=%b, required a fall within 20 cycles", fifo_rd);
        end
        repeat (3) @(posedge clk);
        #1 disp_rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (fifo_rd !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_abort: fifo_rd=%b busy=%b, required 1/0", fifo_rd, busy);
        end
        src_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 disp_rst = 1'b1;
        src_q.delete();
        clear_logs();
        repeat (20) @(negedge clk);
        checks++;
        if (valid_cycles != 0 || got_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL midrst_no_data: valid_cycles=%0d bytes=%0d, required 0/0", valid_cycles, got_q.size());
        end
    endtask

`ifdef ICEVGA_FIFO_STATS_EN
    task automatic test_stats();
        bit ok;
        @(posedge clk);
        #1 disp_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 disp_rst = 1'b1;
        for (int i = 0; i < 300; i++) src_q.push_back(8'($urandom));
        src_en = 1'b1;
        wait_got(300, 300 * PERIOD + 100, ok);
        quiesce();
        checks++;
        if (!ok || rd_count !== 16'd300) begin
            errors++;
            $display("[TB] FAIL stats_count: rd_count=%0d, required 300", rd_count);
        end
        @(posedge clk);
        #1 force dut.rd_count = 16'hFFFF;
        @(posedge clk);
        #1 release dut.rd_count;
        src_q.push_back(8'h5A);
        src_en = 1'b1;
        wait_got(1, 50, ok);
        quiesce();
        checks++;
        if (!ok || rd_count !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL stats_wrap: rd_count=%h, required 0000", rd_count);
        end
    endtask
`endif

    initial begin
        disp_rst  = 1'b0;
        out_ready = 1'b1;
        src_en    = 1'b1;
        src_q.push_back(8'h11);
        src_q.push_back(8'h22);
        src_q.push_back(8'h33);
        test_reset();
        quiesce();
        test_single_byte();
        quiesce();
        test_stream();
        quiesce();
        test_backpressure();
        quiesce();
        test_random_ready();
        quiesce();
        test_reset_mid_read();
        quiesce();
`ifdef ICEVGA_FIFO_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
